pi_step_controller: RTL and testbench

- FSM that sequences the 5x5 lane-permutation datapath.
- Loads the 25-bit line and seeds i=j=3.
- Per step: reads the bit at the current index, computes the next i (2i+3j mod 5, adding 5 repeatedly while the result is negative), updates i/j, and writes the held bit back to the latched index.
- Runs until the datapath reports done (i=j=3 again) or a step limit is reached, then pulses done_o.
- Sits between the top-level start/ready handshake and the datapath control inputs.

---
 rtl/pi_ctrl_pkg.sv | 19 +
 rtl/pi_step_counter.sv | 23 ++
 rtl/pi_step_controller.sv | 169 ++++++++++++++++
 tb/tb_pi_step_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pi_ctrl_pkg.sv
// Shared definitions for the pi-step permutation controller: default sizing and FSM state codes.
package pi_ctrl_pkg;

  localparam int DEF_NUM_STEPS = 24;
  localparam int DEF_MAX_FIX   = 4;
  localparam int DEF_CNT_W     = 5;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_READ  = 3'd2;
  localparam state_t S_CALC  = 3'd3;
  localparam state_t S_FIX   = 3'd4;
  localparam state_t S_STEP  = 3'd5;
  localparam state_t S_WRITE = 3'd6;
  localparam state_t S_FIN   = 3'd7;

endpackage

// File: rtl/pi_step_counter.sv
// Clearable up-counter that saturates at LIMIT; used for the step count and the FIX watchdog.
module pi_step_counter #(
  parameter int W     = 5,
  parameter int LIMIT = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pi_step_controller.sv
// FSM sequencing the 5x5 lane-permutation datapath (load, then read/calc/fix/step/write per step).
// Define PI_CTRL_TIMEOUT_EN to add the FIX-loop watchdog and its sticky err flag.
module pi_step_controller
  import pi_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int MAX_FIX   = DEF_MAX_FIX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic             dp_done,
  output logic             ready,
  output logic             busy,
  output logic             done_o,
  output logic             err,
  output logic [CNT_W-1:0] step_cnt,
  output logic             IJen,
  output logic             initLine,
  output logic             IJregen,
  output logic             read,
  output logic             writeVal,
  output logic             writeMemReg,
  output logic             isArith,
  output logic             ldTillPositive,
  output logic             waitCalNexti,
  output logic             update,
  output logic             write,
  output logic             enable,
  output logic             ALUop,
  output logic             fb3j,
  output logic             fbeq
);

  state_t state;
  state_t nextState;
  logic   runStart;
  logic   lastStep;
  logic   fixTimeout;

  assign runStart = (state == S_IDLE) && start;
  assign lastStep = dp_done || (step_cnt == CNT_W'(NUM_STEPS - 1));

  pi_step_counter #(
    .W     (CNT_W),
    .LIMIT (NUM_STEPS)
  ) uStepCnt (
    .clk (clk),
    .rst (rst),
    .clr (runStart),
    .inc (state == S_WRITE),
    .cnt (step_cnt)
  );

`ifdef PI_CTRL_TIMEOUT_EN
  localparam int FIX_W = $clog2(MAX_FIX + 1);

  logic [FIX_W-1:0] fixCnt;
  logic             errReg;

  // Counts FIX cycles since the last CALC; the MAX_FIX-th FIX cycle still seeing sign=1 aborts.
  pi_step_counter #(
    .W     (FIX_W),
    .LIMIT (MAX_FIX)
  ) uFixCnt (
    .clk (clk),
    .rst (rst),
    .clr (state == S_CALC),
    .inc (state == S_FIX),
    .cnt (fixCnt)
  );

  assign fixTimeout = (state == S_FIX) && sign && (fixCnt == FIX_W'(MAX_FIX - 1));

  always_ff @(posedge clk) begin
    if (!rst || runStart) begin
      errReg <= 1'b0;
    end else if (fixTimeout) begin
      errReg <= 1'b1;
    end
  end

  assign err = errReg;
`else
  logic unusedMaxFix;

  // MAX_FIX only matters when the watchdog is built in.
  assign unusedMaxFix = ^MAX_FIX;
  assign fixTimeout   = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (start) nextState = S_LOAD;
      S_LOAD:  nextState = S_READ;
      S_READ:  nextState = S_CALC;
      S_CALC:  nextState = sign ? S_FIX : S_STEP;
      S_FIX: begin
        if (fixTimeout)  nextState = S_FIN;
        else if (!sign)  nextState = S_STEP;
      end
      S_STEP:  nextState = S_WRITE;
      S_WRITE: nextState = lastStep ? S_FIN : S_READ;
      S_FIN:   nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  assign ready  = (state == S_IDLE);
  assign busy   = (state != S_IDLE);
  assign enable = busy;
  assign done_o = (state == S_FIN);
  assign ALUop  = 1'b0;
  assign fb3j   = 1'b0;
  assign fbeq   = 1'b0;

  always_comb begin
    IJen           = 1'b0;
    initLine       = 1'b0;
    IJregen        = 1'b0;
    read           = 1'b0;
    writeVal       = 1'b0;
    writeMemReg    = 1'b0;
    isArith        = 1'b0;
    ldTillPositive = 1'b0;
    waitCalNexti   = 1'b0;
    update         = 1'b0;
    write          = 1'b0;
    case (state)
      S_LOAD: begin
        initLine = 1'b1;
        IJen     = 1'b1;
        IJregen  = 1'b1;
      end
      S_READ: begin
        read        = 1'b1;
        writeVal    = 1'b1;
        writeMemReg = 1'b1;
      end
      S_CALC: begin
        isArith        = 1'b1;
        ldTillPositive = 1'b1;
      end
      S_FIX: begin
        waitCalNexti   = 1'b1;
        ldTillPositive = 1'b1;
      end
      S_STEP: begin
        update  = 1'b1;
        IJregen = 1'b1;
      end
      S_WRITE: write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pi_step_controller.sv
// Directed bench for pi_step_controller; control vectors per state are hand-written constants.
module tb_pi_step_controller;

  localparam int CNT_W = 5;

  // {ready,busy,done_o, IJen,initLine,IJregen, read,writeVal,writeMemReg,
  //  isArith,ldTillPositive,waitCalNexti, update,write, enable, ALUop,fb3j,fbeq}
  localparam logic [17:0] E_IDLE = 18'b1_0_0_000_000_000_00_0_000;
  localparam logic [17:0] E_LOAD = 18'b0_1_0_111_000_000_00_1_000;
  localparam logic [17:0] E_READ = 18'b0_1_0_000_111_000_00_1_000;
  localparam logic [17:0] E_CALC = 18'b0_1_0_000_000_110_00_1_000;
  localparam logic [17:0] E_FIX  = 18'b0_1_0_000_000_011_00_1_000;
  localparam logic [17:0] E_STEP = 18'b0_1_0_001_000_000_10_1_000;
  localparam logic [17:0] E_WRIT = 18'b0_1_0_000_000_000_01_1_000;
  localparam logic [17:0] E_FIN  = 18'b0_1_1_000_000_000_00_1_000;

  logic clk = 1'b0;
  logic rst, start, sign, dp_done;
  logic ready, busy, done_o, err;
  logic [CNT_W-1:0] step_cnt;
  logic IJen, initLine, IJregen, read, writeVal, writeMemReg, isArith;
  logic ldTillPositive, waitCalNexti, update, write, enable, ALUop, fb3j, fbeq;
  logic [17:0] ctl;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wcnt = 0;
  logic countWrites = 1'b0;

  always #5 clk = ~clk;

  pi_step_controller dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sign           (sign),
    .dp_done        (dp_done),
    .ready          (ready),
    .busy           (busy),
    .done_o         (done_o),
    .err            (err),
    .step_cnt       (step_cnt),
    .IJen           (IJen),
    .initLine       (initLine),
    .IJregen        (IJregen),
    .read           (read),
    .writeVal       (writeVal),
    .writeMemReg    (writeMemReg),
    .isArith        (isArith),
    .ldTillPositive (ldTillPositive),
    .waitCalNexti   (waitCalNexti),
    .update         (update),
    .write          (write),
    .enable         (enable),
    .ALUop          (ALUop),
    .fb3j           (fb3j),
    .fbeq           (fbeq)
  );

  assign ctl = {ready, busy, done_o, IJen, initLine, IJregen, read, writeVal, writeMemReg,
                isArith, ldTillPositive, waitCalNexti, update, write, enable, ALUop, fb3j, fbeq};

  always @(negedge clk) if (countWrites && write) wcnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic stepTo(input string tag, input logic [17:0] exp);
    tick();
    check(tag, 32'(ctl), 32'(exp));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sign = 1'b0; dp_done = 1'b0;
    tick();
    tick();
    check("rst_ctl", 32'(ctl), 32'(E_IDLE));
    check("rst_cnt", 32'(step_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    stepTo("idle_hold", E_IDLE);

    // basic run: three steps, dp_done during the third WRITE
    start = 1'b1;
    cyc = 0;
    stepTo("b_load", E_LOAD);
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      stepTo($sformatf("b_read%0d", s), E_READ);
      stepTo($sformatf("b_calc%0d", s), E_CALC);
      stepTo($sformatf("b_step%0d", s), E_STEP);
      stepTo($sformatf("b_write%0d", s), E_WRIT);
      check($sformatf("b_cnt%0d", s), 32'(step_cnt), 32'(s));
      if (s == 2) dp_done = 1'b1;
    end
    stepTo("b_fin", E_FIN);
    check("b_fin_cycle", 32'(cyc), 32'd14);
    check("b_fin_cnt", 32'(step_cnt), 32'd3);
    dp_done = 1'b0;
    stepTo("b_idle", E_IDLE);
    check("b_idle_cnt", 32'(step_cnt), 32'd3);

    // FIX loop of exactly two cycles
    start = 1'b1;
    stepTo("f_load", E_LOAD);
    start = 1'b0;
    check("f_cnt_clr", 32'(step_cnt), 32'd0);
    stepTo("f_read", E_READ);
    stepTo("f_calc", E_CALC);
    sign = 1'b1;
    stepTo("f_fix1", E_FIX);
    stepTo("f_fix2", E_FIX);
    sign = 1'b0;
    stepTo("f_step", E_STEP);
    stepTo("f_write", E_WRIT);
    dp_done = 1'b1;
    stepTo("f_fin", E_FIN);
    dp_done = 1'b0;
    check("f_cnt", 32'(step_cnt), 32'd1);
    stepTo("f_idle", E_IDLE);

    // reset while in FIX abandons the run
    start = 1'b1;
    stepTo("r_load", E_LOAD);
    start = 1'b0;
    stepTo("r_read0", E_READ);
    stepTo("r_calc0", E_CALC);
    stepTo("r_step0", E_STEP);
    stepTo("r_write0", E_WRIT);
    stepTo("r_read1", E_READ);
    check("r_cnt1", 32'(step_cnt), 32'd1);
    stepTo("r_calc1", E_CALC);
    sign = 1'b1;
    stepTo("r_fix", E_FIX);
    rst = 1'b0;
    stepTo("r_rst1", E_IDLE);
    check("r_rst1_cnt", 32'(step_cnt), 32'd0);
    stepTo("r_rst2", E_IDLE);
    rst = 1'b1;
    sign = 1'b0;
    stepTo("r_after", E_IDLE);

    // step limit with start held high throughout (ignored while busy)
    start = 1'b1;
    stepTo("l_load", E_LOAD);
    wcnt = 0;
    countWrites = 1'b1;
    for (int s = 0; s < 24; s++) begin
      stepTo($sformatf("l_read%0d", s), E_READ);
      stepTo($sformatf("l_calc%0d", s), E_CALC);
      stepTo($sformatf("l_step%0d", s), E_STEP);
      stepTo($sformatf("l_write%0d", s), E_WRIT);
      check($sformatf("l_cnt%0d", s), 32'(step_cnt), 32'(s));
    end
    stepTo("l_fin", E_FIN);
    countWrites = 1'b0;
    check("l_writes", 32'(wcnt), 32'd24);
    check("l_fin_cnt", 32'(step_cnt), 32'd24);
    stepTo("l_idle_nostart", E_IDLE);
    start = 1'b0;
    stepTo("l_idle2", E_IDLE);
    check("l_cnt_hold", 32'(step_cnt), 32'd24);

    // FIX stuck with sign=1
    start = 1'b1;
    stepTo("t_load", E_LOAD);
    start = 1'b0;
    stepTo("t_read", E_READ);
    stepTo("t_calc", E_CALC);
    sign = 1'b1;
    for (int k = 0; k < 4; k++) stepTo($sformatf("t_fix%0d", k), E_FIX);
`ifdef PI_CTRL_TIMEOUT_EN
    stepTo("t_fin", E_FIN);
    check("t_err_fin", 32'(err), 32'd1);
    check("t_cnt", 32'(step_cnt), 32'd0);
    sign = 1'b0;
    stepTo("t_idle", E_IDLE);
    check("t_err_idle", 32'(err), 32'd1);
    stepTo("t_idle2", E_IDLE);
    check("t_err_idle2", 32'(err), 32'd1);
    start = 1'b1;
    stepTo("t_restart", E_LOAD);
    start = 1'b0;
    check("t_err_clr", 32'(err), 32'd0);
    stepTo("t_read2", E_READ);
    stepTo("t_calc2", E_CALC);
    stepTo("t_step2", E_STEP);
`else
    stepTo("t_fix4", E_FIX);
    check("t_err0", 32'(err), 32'd0);
    stepTo("t_fix5", E_FIX);
    sign = 1'b0;
    stepTo("t_step", E_STEP);
    check("t_err1", 32'(err), 32'd0);
`endif
    stepTo("t_write", E_WRIT);
    dp_done = 1'b1;
    stepTo("t_done", E_FIN);
    dp_done = 1'b0;
    check("t_done_cnt", 32'(step_cnt), 32'd1);
    stepTo("t_end", E_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
